mem_stage_ctrl: RTL and testbench



---
 rtl/mem_stage_ctrl.sv | 142 ++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// Memory-stage access controller: drives a req/ack data memory for loads/stores,
// stalls upstream while an access is outstanding and bubbles MEM2WB meanwhile.
`ifndef WIDTH
`define WIDTH 32
`endif

module mem_stage_ctrl #(
    parameter int WIDTH   = `WIDTH,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             regwrite_in,
    input  logic             memtoreg_in,
    input  logic             memread_in,
    input  logic             memwrite_in,
    input  logic [WIDTH-1:0] aluout_in,
    input  logic [WIDTH-1:0] writedata_in,
    input  logic [4:0]       regaddr_in,
    output logic             regwrite_mem,
    output logic             memtoreg_mem,
    output logic [WIDTH-1:0] readdata_mem,
    output logic [WIDTH-1:0] aluout_mem,
    output logic [4:0]       regaddr_mem,
    output logic             stall_mem,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    input  logic [WIDTH-1:0] dmem_rdata,
    input  logic             dmem_ack,
    output logic             err_mem
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           r_state;
    logic             r_h_regwrite;
    logic             r_h_memtoreg;
    logic             r_h_we;
    logic [WIDTH-1:0] r_h_addr;
    logic [WIDTH-1:0] r_h_wdata;
    logic [4:0]       r_h_regaddr;
    logic [WIDTH-1:0] r_rdata_q;
    logic [CW-1:0]    r_cnt;
    logic             r_err;

    logic w_memop;
    assign w_memop = memread_in | memwrite_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_h_regwrite <= 1'b0;
            r_h_memtoreg <= 1'b0;
            r_h_we       <= 1'b0;
            r_h_addr     <= '0;
            r_h_wdata    <= '0;
            r_h_regaddr  <= '0;
            r_rdata_q    <= '0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_memop) begin
                        r_h_regwrite <= regwrite_in;
                        // A simultaneous read+write is treated as a store: no load result.
                        r_h_memtoreg <= memtoreg_in & ~memwrite_in;
                        r_h_we       <= memwrite_in;
                        r_h_addr     <= aluout_in;
                        r_h_wdata    <= writedata_in;
                        r_h_regaddr  <= regaddr_in;
                        r_cnt        <= '0;
                        r_state      <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (dmem_ack) begin
                        r_rdata_q <= r_h_we ? '0 : dmem_rdata;
                        r_state   <= S_DONE;
                    end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                        r_rdata_q <= '0;
                        r_err     <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Reset gates every output, including the combinational pass-through path.
    always_comb begin
        regwrite_mem = 1'b0;
        memtoreg_mem = 1'b0;
        readdata_mem = '0;
        aluout_mem   = '0;
        regaddr_mem  = '0;
        stall_mem    = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        dmem_addr    = '0;
        dmem_wdata   = '0;
        if (rst) begin
            case (r_state)
                S_IDLE: begin
                    stall_mem = w_memop;
                    if (!w_memop) begin
                        regwrite_mem = regwrite_in;
                        memtoreg_mem = memtoreg_in;
                        aluout_mem   = aluout_in;
                        regaddr_mem  = regaddr_in;
                    end
                end
                S_BUSY: begin
                    stall_mem  = 1'b1;
                    dmem_req   = 1'b1;
                    dmem_we    = r_h_we;
                    dmem_addr  = r_h_addr;
                    dmem_wdata = r_h_wdata;
                end
                S_DONE: begin
                    readdata_mem = r_rdata_q;
                    aluout_mem   = r_h_addr;
                    regwrite_mem = r_h_regwrite;
                    memtoreg_mem = r_h_memtoreg;
                    regaddr_mem  = r_h_regaddr;
                end
                default: ;
            endcase
        end
    end

    assign err_mem = r_err & rst;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl (TIMEOUT=4): pass-through, loads, stores,
// read/write conflict, timeout, back-to-back accesses and reset behaviour.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        regwrite_in, memtoreg_in, memread_in, memwrite_in;
    logic [31:0] aluout_in, writedata_in, dmem_rdata;
    logic [4:0]  regaddr_in;
    logic        dmem_ack;
    logic        regwrite_mem, memtoreg_mem, stall_mem, dmem_req, dmem_we, err_mem;
    logic [31:0] readdata_mem, aluout_mem, dmem_addr, dmem_wdata;
    logic [4:0]  regaddr_mem;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.WIDTH(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .regwrite_in(regwrite_in), .memtoreg_in(memtoreg_in),
        .memread_in(memread_in), .memwrite_in(memwrite_in),
        .aluout_in(aluout_in), .writedata_in(writedata_in), .regaddr_in(regaddr_in),
        .regwrite_mem(regwrite_mem), .memtoreg_mem(memtoreg_mem),
        .readdata_mem(readdata_mem), .aluout_mem(aluout_mem), .regaddr_mem(regaddr_mem),
        .stall_mem(stall_mem), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .err_mem(err_mem)
    );

    // {stall, regwrite, memtoreg, regaddr, aluout, readdata}
    wire [71:0] w_wb = {stall_mem, regwrite_mem, memtoreg_mem, regaddr_mem, aluout_mem, readdata_mem};
    // {req, we, addr, wdata}
    wire [65:0] w_dm = {dmem_req, dmem_we, dmem_addr, dmem_wdata};

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic clear_inputs();
        regwrite_in = 0; memtoreg_in = 0; memread_in = 0; memwrite_in = 0;
        aluout_in = 0; writedata_in = 0; regaddr_in = 0; dmem_rdata = 0; dmem_ack = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 0; memread_in = 1; memtoreg_in = 1; regwrite_in = 1;
        aluout_in = 32'h55; regaddr_in = 5'd3;
        @(negedge clk);
        vecs++; if (w_wb !== 72'h0) begin errs++; $display("FAIL reset_wb: got %h want %h", w_wb, 72'h0); end
        vecs++; if (w_dm !== 66'h0) begin errs++; $display("FAIL reset_dm: got %h want %h", w_dm, 66'h0); end
        vecs++; if (err_mem !== 1'b0) begin errs++; $display("FAIL reset_err: got %b want 0", err_mem); end
        step(); rst = 1;
        @(negedge clk);
        vecs++; if (w_wb !== {1'b1, 71'h0}) begin errs++; $display("FAIL reset_release_stall: got %h want %h", w_wb, {1'b1, 71'h0}); end
        step(); dmem_ack = 1; dmem_rdata = 32'h1111;
        @(negedge clk);
        vecs++; if (w_dm !== {1'b1, 1'b0, 32'h55, 32'h0}) begin errs++; $display("FAIL reset_busy_dm: got %h want %h", w_dm, {1'b1, 1'b0, 32'h55, 32'h0}); end
        step(); dmem_ack = 0;
        @(negedge clk);
        vecs++; if (w_wb !== {1'b0, 1'b1, 1'b1, 5'd3, 32'h55, 32'h1111}) begin errs++; $display("FAIL reset_done_wb: got %h want %h", w_wb, {1'b0, 1'b1, 1'b1, 5'd3, 32'h55, 32'h1111}); end
        step(); clear_inputs();
    endtask

    task automatic test_alu_pass();
        regwrite_in = 1; aluout_in = 32'h0000_1234; regaddr_in = 5'd5;
        @(negedge clk);
        vecs++; if (w_wb !== {1'b0, 1'b1, 1'b0, 5'd5, 32'h1234, 32'h0}) begin errs++; $display("FAIL alu_pass1: got %h want %h", w_wb, {1'b0, 1'b1, 1'b0, 5'd5, 32'h1234, 32'h0}); end
        vecs++; if (w_dm !== 66'h0) begin errs++; $display("FAIL alu_pass1_dm: got %h want %h", w_dm, 66'h0); end
        step(); regwrite_in = 0; memtoreg_in = 1; aluout_in = 32'hFFFF_FFFF; regaddr_in = 5'd31;
        writedata_in = 32'h1357;
        @(negedge clk);
        vecs++; if (w_wb !== {1'b0, 1'b0, 1'b1, 5'd31, 32'hFFFF_FFFF, 32'h0}) begin errs++; $display("FAIL alu_pass2: got %h want %h", w_wb, {1'b0, 1'b0, 1'b1, 5'd31, 32'hFFFF_FFFF, 32'h0}); end
        step(); clear_inputs();
    endtask

    task automatic test_load();
        memread_in = 1; memtoreg_in = 1; regwrite_in = 1; aluout_in = 32'h40; regaddr_in = 5'd9;
        dmem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        vecs++; if (w_wb !== {1'b1, 71'h0}) begin errs++; $display("FAIL load_idle: got %h want %h", w_wb, {1'b1, 71'h0}); end
        for (int c = 1; c <= 3; c++) begin
            step(); dmem_ack = (c == 3);
            @(negedge clk);
            vecs++; if ({w_wb, w_dm} !== {1'b1, 71'h0, 1'b1, 1'b0, 32'h40, 32'h0}) begin errs++; $display("FAIL load_busy%0d: got %h/%h want stall+req addr 40", c, w_wb, w_dm); end
        end
        step(); dmem_ack = 0;
        @(negedge clk);
        vecs++; if (w_wb !== {1'b0, 1'b1, 1'b1, 5'd9, 32'h40, 32'hDEADBEEF}) begin errs++; $display("FAIL load_done: got %h want %h", w_wb, {1'b0, 1'b1, 1'b1, 5'd9, 32'h40, 32'hDEADBEEF}); end
        vecs++; if (w_dm !== 66'h0) begin errs++; $display("FAIL load_done_dm: got %h want %h", w_dm, 66'h0); end
        step(); clear_inputs();
    endtask

    task automatic test_store();
        memwrite_in = 1; writedata_in = 32'hA5A5A5A5; aluout_in = 32'h80; regaddr_in = 5'd4;
        dmem_rdata = 32'h7777_7777;
        @(negedge clk);
        vecs++; if (w_wb !== {1'b1, 71'h0}) begin errs++; $display("FAIL store_idle: got %h want %h", w_wb, {1'b1, 71'h0}); end
        step(); dmem_ack = 1;
        @(negedge clk);
        vecs++; if (w_dm !== {1'b1, 1'b1, 32'h80, 32'hA5A5A5A5}) begin errs++; $display("FAIL store_busy_dm: got %h want %h", w_dm, {1'b1, 1'b1, 32'h80, 32'hA5A5A5A5}); end
        vecs++; if (stall_mem !== 1'b1) begin errs++; $display("FAIL store_busy_stall: got %b want 1", stall_mem); end
        step(); dmem_ack = 0;
        @(negedge clk);
        vecs++; if (w_wb !== {1'b0, 1'b0, 1'b0, 5'd4, 32'h80, 32'h0}) begin errs++; $display("FAIL store_done: got %h want %h", w_wb, {1'b0, 1'b0, 1'b0, 5'd4, 32'h80, 32'h0}); end
        vecs++; if (w_dm !== 66'h0) begin errs++; $display("FAIL store_done_dm: got %h want %h", w_dm, 66'h0); end
        step(); clear_inputs();
    endtask

    task automatic test_rw_conflict();
        memread_in = 1; memwrite_in = 1; memtoreg_in = 1; regwrite_in = 1;
        aluout_in = 32'hC0; writedata_in = 32'h0BAD_F00D; regaddr_in = 5'd2; dmem_rdata = 32'hFFFF_FFFF;
        step(); dmem_ack = 1;
        @(negedge clk);
        vecs++; if (w_dm !== {1'b1, 1'b1, 32'hC0, 32'h0BAD_F00D}) begin errs++; $display("FAIL rw_busy_dm: got %h want %h", w_dm, {1'b1, 1'b1, 32'hC0, 32'h0BAD_F00D}); end
        step(); dmem_ack = 0;
        @(negedge clk);
        vecs++; if (w_wb !== {1'b0, 1'b1, 1'b0, 5'd2, 32'hC0, 32'h0}) begin errs++; $display("FAIL rw_done: got %h want %h", w_wb, {1'b0, 1'b1, 1'b0, 5'd2, 32'hC0, 32'h0}); end
        step(); clear_inputs();
    endtask

    task automatic test_timeout();
        memread_in = 1; memtoreg_in = 1; regwrite_in = 1; aluout_in = 32'h100; regaddr_in = 5'd12;
        dmem_rdata = 32'h1234_5678;
        @(negedge clk);
        vecs++; if ({stall_mem, err_mem} !== 2'b10) begin errs++; $display("FAIL to_idle: got %b want 10", {stall_mem, err_mem}); end
        for (int c = 1; c <= 4; c++) begin
            step();
            @(negedge clk);
            vecs++; if ({stall_mem, w_dm} !== {1'b1, 1'b1, 1'b0, 32'h100, 32'h0}) begin errs++; $display("FAIL to_busy%0d: got %b/%h want stall+req addr 100", c, stall_mem, w_dm); end
        end
        step();
        @(negedge clk);
        vecs++; if (w_wb !== {1'b0, 1'b1, 1'b1, 5'd12, 32'h100, 32'h0}) begin errs++; $display("FAIL to_done: got %h want %h", w_wb, {1'b0, 1'b1, 1'b1, 5'd12, 32'h100, 32'h0}); end
        vecs++; if (err_mem !== 1'b1) begin errs++; $display("FAIL to_err: got %b want 1", err_mem); end
        step(); clear_inputs();
        @(negedge clk);
        vecs++; if (err_mem !== 1'b1) begin errs++; $display("FAIL to_err_sticky: got %b want 1", err_mem); end
    endtask

    task automatic test_back_to_back();
        memread_in = 1; memtoreg_in = 1; regwrite_in = 1; aluout_in = 32'h10; regaddr_in = 5'd6;
        step(); dmem_ack = 1; dmem_rdata = 32'hAAAA;
        @(negedge clk);
        vecs++; if (w_dm !== {1'b1, 1'b0, 32'h10, 32'h0}) begin errs++; $display("FAIL b2b_a_busy: got %h want %h", w_dm, {1'b1, 1'b0, 32'h10, 32'h0}); end
        step(); dmem_ack = 0;
        @(negedge clk);
        vecs++; if (w_wb !== {1'b0, 1'b1, 1'b1, 5'd6, 32'h10, 32'hAAAA}) begin errs++; $display("FAIL b2b_a_done: got %h want %h", w_wb, {1'b0, 1'b1, 1'b1, 5'd6, 32'h10, 32'hAAAA}); end
        step(); aluout_in = 32'h20; regaddr_in = 5'd7;
        @(negedge clk);
        vecs++; if ({w_wb, w_dm} !== {1'b1, 71'h0, 66'h0}) begin errs++; $display("FAIL b2b_b_idle: got %h/%h want stall only", w_wb, w_dm); end
        step(); dmem_ack = 1; dmem_rdata = 32'hBBBB;
        @(negedge clk);
        vecs++; if (w_dm !== {1'b1, 1'b0, 32'h20, 32'h0}) begin errs++; $display("FAIL b2b_b_busy: got %h want %h", w_dm, {1'b1, 1'b0, 32'h20, 32'h0}); end
        step(); dmem_ack = 0;
        @(negedge clk);
        vecs++; if (w_wb !== {1'b0, 1'b1, 1'b1, 5'd7, 32'h20, 32'hBBBB}) begin errs++; $display("FAIL b2b_b_done: got %h want %h", w_wb, {1'b0, 1'b1, 1'b1, 5'd7, 32'h20, 32'hBBBB}); end
        vecs++; if (err_mem !== 1'b1) begin errs++; $display("FAIL b2b_err_sticky: got %b want 1", err_mem); end
        step(); clear_inputs();
    endtask

    task automatic test_reset_mid_busy();
        memread_in = 1; memtoreg_in = 1; regwrite_in = 1; aluout_in = 32'h44; regaddr_in = 5'd8;
        step();
        step();
        #1;
        vecs++; if (dmem_req !== 1'b1) begin errs++; $display("FAIL rmb_req_before: got %b want 1", dmem_req); end
        rst = 0;
        #1;
        vecs++; if ({w_wb, w_dm, err_mem} !== 139'h0) begin errs++; $display("FAIL rmb_async: got %h/%h/%b want all 0", w_wb, w_dm, err_mem); end
        clear_inputs();
        step(); rst = 1; dmem_ack = 1; dmem_rdata = 32'hCAFE;
        @(negedge clk);
        vecs++; if ({w_wb, w_dm} !== 138'h0) begin errs++; $display("FAIL stray_ack1: got %h/%h want all 0", w_wb, w_dm); end
        step(); dmem_ack = 0;
        @(negedge clk);
        vecs++; if ({w_wb, w_dm} !== 138'h0) begin errs++; $display("FAIL stray_ack2: got %h/%h want all 0", w_wb, w_dm); end
    endtask

    initial begin
        test_reset();
        test_alu_pass();
        test_load();
        test_store();
        test_rw_conflict();
        test_timeout();
        test_back_to_back();
        test_reset_mid_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
